// File: rtl/log_mult_arbiter.sv
// ---------------------------------------------------------------------------
// log_mult_arbiter
//
// Purpose: shares one approximate (Mitchell logarithmic) 8x8 signed
// multiplier among N_REQ operand requesters. A round-robin arbiter issues
// at most one operand pair per cycle. A tag pipeline tracks the requester
// ID of each product alongside the fixed-latency multiplier. Finished
// products are written into a small response FIFO together with that ID.
// A single credit counter (pipeline + FIFO occupancy) keeps the FIFO from
// overflowing.
//
// Optional feature macro: ZERO_BYPASS_EN
//   defined   : a tag bit records (A==0 || B==0) at issue, and that entry's
//               response data is forced to zero at writeback.
//   undefined : the multiplier output is written unchanged.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [N_REQ]     per-requester operand valid
//   req_ready  out  [N_REQ]     per-requester accept, one-hot or zero
//   req_a      in   [8*N_REQ]   signed operand A, requester i at [8i+7:8i]
//   req_b      in   [8*N_REQ]   signed operand B, same packing
//   rsp_valid  out              response FIFO head valid
//   rsp_ready  in               consumer accepts head
//   rsp_data   out  [16]        signed (approximate) product at head
//   rsp_id     out  [ID_W]      requester index at head
//   busy       out              any product in the pipeline or the FIFO
// ---------------------------------------------------------------------------

// Mitchell logarithmic multiplier, 8x8 signed -> 16 signed.
// The combinational product is followed by LAT register stages, so the
// result is valid LAT cycles after a/b are applied. This block has no reset.
// Its output is meaningful only when the caller's matching tag is valid.
module approx_log_multiplier #(
    parameter int LAT = 2
) (
    input  logic               clk,
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] p
);

    // Position of the leading one (characteristic of log2).
    function automatic logic [2:0] lead_one(input logic [7:0] x);
        lead_one = '0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) begin
                lead_one = 3'(i);
            end
        end
    endfunction

    logic [7:0]         mag_a;
    logic [7:0]         mag_b;
    logic [2:0]         k_a;
    logic [2:0]         k_b;
    logic [7:0]         sh_a;
    logic [7:0]         sh_b;
    logic [7:0]         f_sum;
    logic [3:0]         k_sum;
    logic [22:0]        wide;
    logic [15:0]        mag_p;
    logic signed [15:0] p_d;
    logic [LAT-1:0][15:0] p_pipe_q;

    always_comb begin
        // Magnitudes. For -128, the 8-bit negation gives 8'h80, which is
        // the correct unsigned magnitude.
        mag_a = a[7] ? 8'(-a) : 8'(a);
        mag_b = b[7] ? 8'(-b) : 8'(b);
        k_a   = lead_one(mag_a);
        k_b   = lead_one(mag_b);
        // Normalise so the leading one sits at bit 7. The 7 bits below it
        // are the mantissa fraction in units of 1/128.
        sh_a  = mag_a << (3'd7 - k_a);
        sh_b  = mag_b << (3'd7 - k_b);
        f_sum = {1'b0, sh_a[6:0]} + {1'b0, sh_b[6:0]};
        k_sum = {1'b0, k_a} + {1'b0, k_b};
        // Antilog:
        //   if fa+fb < 1, the result is 2^k * (1 + fa + fb);
        //   otherwise it is 2^(k+1) * (fa + fb).
        // The fraction keeps 7 bits below the binary point; they are
        // dropped afterwards.
        if (!f_sum[7]) begin
            wide = {15'd0, 1'b1, f_sum[6:0]} << k_sum;
        end else begin
            wide = {15'd0, f_sum} << (k_sum + 4'd1);
        end
        mag_p = wide[22:7];
        // The log domain cannot represent zero, so force it explicitly.
        if (mag_a == 8'd0 || mag_b == 8'd0) begin
            p_d = '0;
        end else if (a[7] ^ b[7]) begin
            p_d = -$signed(mag_p);
        end else begin
            p_d = $signed(mag_p);
        end
    end

    always_ff @(posedge clk) begin
        p_pipe_q[0] <= p_d;
        for (int i = 1; i < LAT; i++) begin
            p_pipe_q[i] <= p_pipe_q[i-1];
        end
    end

    assign p = $signed(p_pipe_q[LAT-1]);

endmodule

module log_mult_arbiter #(
    parameter int  N_REQ     = 4,
    parameter int  MULT_LAT  = 2,
    parameter int  RSP_DEPTH = 4,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1),
    localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic signed [15:0]   rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    // ------------------------------------------------------------------
    // Credit and round-robin arbitration
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;
    logic             credit_ok;
    logic             issue;
    logic [ID_W-1:0]  grant_id;
    logic             pop;
    logic             push;

    always_comb begin
        int idx;
        idx       = 0;
        issue     = 1'b0;
        grant_id  = '0;
        // Only the registered count gates issue. A pop in this cycle does
        // not free a slot until the next cycle.
        credit_ok = (inflight_q < CNT_W'(RSP_DEPTH));
        // Gating with rst_n keeps req_ready low while reset is asserted,
        // even when requesters hold valid high.
        if (rst_n && credit_ok) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % N_REQ;
                if (!issue && req_valid[idx]) begin
                    issue    = 1'b1;
                    grant_id = ID_W'(idx);
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(pop);
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = issue && (grant_id == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    assign busy = (inflight_q != '0);

    // ------------------------------------------------------------------
    // Issue: operand registers feeding the multiplier (no reset; qualified
    // by the tag pipeline) and the tag shift register aligned with the
    // product. Stage 0 is loaded together with the operand registers.
    // Stage MULT_LAT coincides with the multiplier output.
    // ------------------------------------------------------------------
    logic signed [7:0]          op_a_d;
    logic signed [7:0]          op_b_d;
    logic signed [7:0]          op_a_q;
    logic signed [7:0]          op_b_q;
    logic signed [15:0]         mult_p;
    logic [MULT_LAT:0]          tag_vld_q;
    logic [MULT_LAT:0][ID_W-1:0] tag_id_q;

    always_comb begin
        op_a_d = $signed(req_a[8*int'(grant_id) +: 8]);
        op_b_d = $signed(req_b[8*int'(grant_id) +: 8]);
    end

    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    approx_log_multiplier #(
        .LAT (MULT_LAT)
    ) u_mult (
        .clk (clk),
        .a   (op_a_q),
        .b   (op_b_q),
        .p   (mult_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= issue;
            tag_id_q[0]  <= grant_id;
            for (int i = 1; i <= MULT_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Writeback data
    // ------------------------------------------------------------------
    logic signed [15:0] wb_data;

`ifdef ZERO_BYPASS_EN
    logic              tag_zero_d;
    logic [MULT_LAT:0] tag_zero_q;

    assign tag_zero_d = (op_a_d == 8'sd0) || (op_b_d == 8'sd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_zero_q <= '0;
        end else begin
            tag_zero_q[0] <= tag_zero_d;
            for (int i = 1; i <= MULT_LAT; i++) begin
                tag_zero_q[i] <= tag_zero_q[i-1];
            end
        end
    end

    assign wb_data = tag_zero_q[MULT_LAT] ? 16'sd0 : mult_p;
`else
    assign wb_data = mult_p;
`endif

    // ------------------------------------------------------------------
    // Response FIFO. The storage has no reset. The outputs are gated by
    // the occupancy count, so stale entries never become visible after a
    // reset.
    // ------------------------------------------------------------------
    logic signed [15:0] mem_data_q [RSP_DEPTH];
    logic [ID_W-1:0]    mem_id_q   [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q;
    logic [CNT_W-1:0]   fifo_cnt_d;
    logic               fifo_full;

    assign push      = tag_vld_q[MULT_LAT];
    assign fifo_full = (fifo_cnt_q == CNT_W'(RSP_DEPTH));
    assign rsp_valid = (fifo_cnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= wb_data;
            mem_id_q[wr_ptr_q]   <= tag_id_q[MULT_LAT];
        end
    end

    assign rsp_data = rsp_valid ? mem_data_q[rd_ptr_q] : 16'sd0;
    assign rsp_id   = rsp_valid ? mem_id_q[rd_ptr_q]   : '0;

    // The credit counter should make this unreachable. A write into a full
    // FIFO means the credit accounting is broken.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && fifo_full));
        end
    end

endmodule

// File: tb/tb_log_mult_arbiter.sv
// Directed testbench for log_mult_arbiter (N_REQ=4, MULT_LAT=2, RSP_DEPTH=4).
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge. Every expected value is a hand-computed constant.
module tb_log_mult_arbiter;

    logic               clk;
    logic               rst_n;
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [31:0]        req_a;
    logic [31:0]        req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic signed [15:0] rsp_data;
    logic [1:0]         rsp_id;
    logic               busy;

    int errors;
    int checks;
    int cyc_no;

    log_mult_arbiter #(
        .N_REQ     (4),
        .MULT_LAT  (2),
        .RSP_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc_no, got, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[8*i +: 8] = 8'(a);
        req_b[8*i +: 8] = 8'(b);
    endtask

    // One clock cycle: drive, sample at the falling edge, check, then step
    // to 1 ns past the next rising edge.
    task automatic cyc(input string name, input logic [3:0] vld, input logic rr,
                       input logic [3:0] exp_rdy, input logic exp_rv,
                       input int exp_id, input int exp_data, input logic exp_busy);
        req_valid = vld;
        rsp_ready = rr;
        @(negedge clk);
        check({name, ".req_ready"}, int'(req_ready), int'(exp_rdy));
        check({name, ".rsp_valid"}, int'(rsp_valid), int'(exp_rv));
        if (exp_rv) begin
            check({name, ".rsp_id"},   int'(rsp_id), exp_id);
            check({name, ".rsp_data"}, int'(rsp_data), exp_data);
        end
        check({name, ".busy"}, int'(busy), int'(exp_busy));
        $display("%s cyc=%0d ready=%b rsp_valid=%b id=%0d data=%0d busy=%b",
                 name, cyc_no, req_ready, rsp_valid, rsp_id, rsp_data, busy);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc_no);
        $fatal(1);
    end

    initial begin
        errors    = 0;
        checks    = 0;
        cyc_no    = 0;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;

        // Reset state, with requesters already asserting valid.
        @(negedge clk);
        check("reset.req_ready", int'(req_ready), 0);
        check("reset.rsp_valid", int'(rsp_valid), 0);
        check("reset.rsp_data",  int'(rsp_data), 0);
        check("reset.rsp_id",    int'(rsp_id), 0);
        check("reset.busy",      int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester: 4*8=32, response at cycle MULT_LAT+2 = 4.
        set_op(0, 4, 8);
        cyc("single", 4'b0001, 1, 4'b0001, 0, 0, 0,  0);
        cyc("single", 4'b0000, 1, 4'b0000, 0, 0, 0,  1);
        cyc("single", 4'b0000, 1, 4'b0000, 0, 0, 0,  1);
        cyc("single", 4'b0000, 1, 4'b0000, 0, 0, 0,  1);
        cyc("single", 4'b0000, 1, 4'b0000, 1, 0, 32, 1);
        cyc("single", 4'b0000, 1, 4'b0000, 0, 0, 0,  0);

        // Rotation: pointer is now 1. Operands (i+1)*2.
        // Credit runs out at cycle 4 (4 in flight). The pop in that cycle
        // does not free a slot until the next cycle.
        for (int i = 0; i < 4; i++) set_op(i, i + 1, 2);
        cyc("rotate", 4'hF, 1, 4'b0010, 0, 0, 0, 0);
        cyc("rotate", 4'hF, 1, 4'b0100, 0, 0, 0, 1);
        cyc("rotate", 4'hF, 1, 4'b1000, 0, 0, 0, 1);
        cyc("rotate", 4'hF, 1, 4'b0001, 0, 0, 0, 1);
        cyc("rotate", 4'hF, 1, 4'b0000, 1, 1, 4, 1);
        cyc("rotate", 4'hF, 1, 4'b0010, 1, 2, 6, 1);
        cyc("rotate", 4'hF, 1, 4'b0100, 1, 3, 8, 1);
        cyc("rotate", 4'hF, 1, 4'b1000, 1, 0, 2, 1);
        cyc("rotate", 4'hF, 1, 4'b0001, 0, 0, 0, 1);
        cyc("rotate", 4'h0, 1, 4'b0000, 1, 1, 4, 1);
        cyc("rotate", 4'h0, 1, 4'b0000, 1, 2, 6, 1);
        cyc("rotate", 4'h0, 1, 4'b0000, 1, 3, 8, 1);
        cyc("rotate", 4'h0, 1, 4'b0000, 1, 0, 2, 1);
        cyc("rotate", 4'h0, 1, 4'b0000, 0, 0, 0, 0);

        // Backpressure with edge operands; pointer is 1.
        // r0:(-128)(-128)=16384  r1:(-4)(8)=-32  r2:3*3 -> Mitchell gives 8
        // r3:0*(-77)=0
        set_op(0, -128, -128);
        set_op(1, -4, 8);
        set_op(2, 3, 3);
        set_op(3, 0, -77);
        cyc("bp", 4'hF, 0, 4'b0010, 0, 0, 0,     0);
        cyc("bp", 4'hF, 0, 4'b0100, 0, 0, 0,     1);
        cyc("bp", 4'hF, 0, 4'b1000, 0, 0, 0,     1);
        cyc("bp", 4'hF, 0, 4'b0001, 0, 0, 0,     1);
        cyc("bp", 4'hF, 0, 4'b0000, 1, 1, -32,   1);
        cyc("bp", 4'hF, 0, 4'b0000, 1, 1, -32,   1);
        cyc("bp", 4'hF, 0, 4'b0000, 1, 1, -32,   1);
        cyc("bp", 4'hF, 0, 4'b0000, 1, 1, -32,   1);
        cyc("bp", 4'hF, 1, 4'b0000, 1, 1, -32,   1);
        cyc("bp", 4'hF, 1, 4'b0010, 1, 2, 8,     1);
        cyc("bp", 4'h0, 1, 4'b0000, 1, 3, 0,     1);
        cyc("bp", 4'h0, 1, 4'b0000, 1, 0, 16384, 1);
        cyc("bp", 4'h0, 1, 4'b0000, 0, 0, 0,     1);
        cyc("bp", 4'h0, 1, 4'b0000, 1, 1, -32,   1);
        cyc("bp", 4'h0, 1, 4'b0000, 0, 0, 0,     0);

        // Reset mid-operation. Pointer is 2. Three products are in the
        // pipeline and one is buffered when reset hits.
        set_op(0, 55, 0);
        cyc("rstmid", 4'hF, 0, 4'b0100, 0, 0, 0, 0);
        cyc("rstmid", 4'hF, 0, 4'b1000, 0, 0, 0, 1);
        cyc("rstmid", 4'hF, 0, 4'b0001, 0, 0, 0, 1);
        cyc("rstmid", 4'hF, 0, 4'b0010, 0, 0, 0, 1);
        check("rstmid.pre_rsp_valid", int'(rsp_valid), 1);
        check("rstmid.pre_busy",      int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rstmid.req_ready", int'(req_ready), 0);
        check("rstmid.rsp_valid", int'(rsp_valid), 0);
        check("rstmid.rsp_data",  int'(rsp_data), 0);
        check("rstmid.rsp_id",    int'(rsp_id), 0);
        check("rstmid.busy",      int'(busy), 0);
        $display("rstmid cyc=%0d reset asserted ready=%b rsp_valid=%b busy=%b",
                 cyc_no, req_ready, rsp_valid, busy);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // First grant goes to requester 0. 55*0 = 0. No stale responses.
        cyc("post", 4'hF, 1, 4'b0001, 0, 0, 0, 0);
        cyc("post", 4'h0, 1, 4'b0000, 0, 0, 0, 1);
        cyc("post", 4'h0, 1, 4'b0000, 0, 0, 0, 1);
        cyc("post", 4'h0, 1, 4'b0000, 0, 0, 0, 1);
        cyc("post", 4'h0, 1, 4'b0000, 1, 0, 0, 1);
        cyc("post", 4'h0, 1, 4'b0000, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
